// File: rtl/bcd_down_counter.sv
// bcd_down_counter: 3-digit cascaded BCD down-counter (000-999) with borrow chain.
//
// Ports:
//   clk       system clock, all state updates on posedge
//   reset     asynchronous active-high, forces RESET_VAL
//   load      synchronous preload strobe (beats dec)
//   load_val  BCD preload value {hundreds, tens, ones}; nibbles > 9 clamp to 9
//   dec       decrement request, sampled each posedge
//   bcd       current count, registered, same packing as load_val
//   zero      1 when bcd == 000 (combinational from the digit registers)
//   done      1-cycle pulse after a dec took the count from 001 to 000
//   borrow    1-cycle pulse after a 000 -> 999 wrap (WRAP = 1 only)
//   HEX0..2   seven-segment codes for ones/tens/hundreds via seg7
//
// Also contains seg7, the shared BCD to seven-segment decoder.

module bcd_down_counter #(
  parameter bit          WRAP      = 1'b0,
  parameter logic [11:0] RESET_VAL = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        dec,
  output logic [11:0] bcd,
  output logic        zero,
  output logic        done,
  output logic        borrow,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2
);

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  logic [3:0] ones_q, tens_q, hund_q;
  logic [3:0] ones_d, tens_d, hund_d;
  logic [3:0] ones_c, tens_c, hund_c;
  logic       done_q, done_d;
  logic       borrow_q, borrow_d;
  logic       b_ones, b_tens;

  always_comb begin
    // Clamped view of the registers: an out-of-range digit self-corrects to 9.
    ones_c   = clamp9(ones_q);
    tens_c   = clamp9(tens_q);
    hund_c   = clamp9(hund_q);
    ones_d   = ones_c;
    tens_d   = tens_c;
    hund_d   = hund_c;
    done_d   = 1'b0;
    borrow_d = 1'b0;
    b_ones   = 1'b0;
    b_tens   = 1'b0;
    if (load) begin
      ones_d = clamp9(load_val[3:0]);
      tens_d = clamp9(load_val[7:4]);
      hund_d = clamp9(load_val[11:8]);
    end else if (dec) begin
      if ({hund_c, tens_c, ones_c} == 12'h000) begin
        if (WRAP) begin
          ones_d   = 4'd9;
          tens_d   = 4'd9;
          hund_d   = 4'd9;
          borrow_d = 1'b1;
        end
      end else begin
        // Each digit steps 9..0 and borrows from the next one on 0 -> 9.
        b_ones = (ones_c == 4'd0);
        ones_d = b_ones ? 4'd9 : ones_c - 4'd1;
        if (b_ones) begin
          b_tens = (tens_c == 4'd0);
          tens_d = b_tens ? 4'd9 : tens_c - 4'd1;
        end
        if (b_tens) begin
          hund_d = (hund_c == 4'd0) ? 4'd9 : hund_c - 4'd1;
        end
        done_d = ({hund_d, tens_d, ones_d} == 12'h000);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_q   <= RESET_VAL[3:0];
      tens_q   <= RESET_VAL[7:4];
      hund_q   <= RESET_VAL[11:8];
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      ones_q   <= ones_d;
      tens_q   <= tens_d;
      hund_q   <= hund_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
    end
  end

  assign bcd    = {hund_q, tens_q, ones_q};
  assign zero   = (bcd == 12'h000);
  assign done   = done_q;
  assign borrow = borrow_q;

  seg7 u_seg_ones (
    .bcd  (ones_q),
    .leds (HEX0)
  );

  seg7 u_seg_tens (
    .bcd  (tens_q),
    .leds (HEX1)
  );

  seg7 u_seg_hund (
    .bcd  (hund_q),
    .leds (HEX2)
  );

endmodule

// seg7: BCD digit to active-low seven-segment code, leds = {g,f,e,d,c,b,a}.
// Non-decimal inputs blank the display.
module seg7 (
  input  logic [3:0] bcd,
  output logic [6:0] leds
);

  always_comb begin
    leds = 7'h7F;
    unique case (bcd)
      4'd0:    leds = 7'h40;
      4'd1:    leds = 7'h79;
      4'd2:    leds = 7'h24;
      4'd3:    leds = 7'h30;
      4'd4:    leds = 7'h19;
      4'd5:    leds = 7'h12;
      4'd6:    leds = 7'h02;
      4'd7:    leds = 7'h78;
      4'd8:    leds = 7'h00;
      4'd9:    leds = 7'h10;
      default: leds = 7'h7F;
    endcase
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
module tb_bcd_down_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_val = 12'h000;
  logic        dec = 1'b0;

  logic [11:0] bcd0, bcd1;
  logic        zero0, zero1, done0, done1, borrow0, borrow1;
  logic [6:0]  h00, h01, h02, h10, h11, h12;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = WRAP 0, index 1 = WRAP 1.
  int cnt[2];
  bit md[2];
  bit mb[2];

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  bcd_down_counter #(.WRAP(1'b0), .RESET_VAL(12'h000)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .bcd      (bcd0),
    .zero     (zero0),
    .done     (done0),
    .borrow   (borrow0),
    .HEX0     (h00),
    .HEX1     (h01),
    .HEX2     (h02)
  );

  bcd_down_counter #(.WRAP(1'b1), .RESET_VAL(12'h000)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .bcd      (bcd1),
    .zero     (zero1),
    .done     (done1),
    .borrow   (borrow1),
    .HEX0     (h10),
    .HEX1     (h11),
    .HEX2     (h12)
  );

  wire [35:0] obs0 = {bcd0, zero0, done0, borrow0, h02, h01, h00};
  wire [35:0] obs1 = {bcd1, zero1, done1, borrow1, h12, h11, h10};

  function automatic int nib(input logic [3:0] n);
    return (n > 4'd9) ? 9 : int'(n);
  endfunction

  // Expected {bcd, zero, done, borrow, HEX2, HEX1, HEX0} for a decimal count.
  function automatic logic [35:0] exp_vec(input int c, input bit d, input bit b);
    int h, t, o;
    h = c / 100;
    t = (c / 10) % 10;
    o = c % 10;
    return {4'(h), 4'(t), 4'(o), (c == 0), d, b, seg_tab[h], seg_tab[t], seg_tab[o]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0;
      md[i]  = 1'b0;
      mb[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input bit ld, input logic [11:0] lv, input bit dc);
    for (int i = 0; i < 2; i++) begin
      md[i] = 1'b0;
      mb[i] = 1'b0;
      if (ld) begin
        cnt[i] = nib(lv[11:8]) * 100 + nib(lv[7:4]) * 10 + nib(lv[3:0]);
      end else if (dc) begin
        if (cnt[i] == 0) begin
          if (i == 1) begin
            cnt[i] = 999;
            mb[i]  = 1'b1;
          end
        end else begin
          cnt[i] = cnt[i] - 1;
          md[i]  = (cnt[i] == 0);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step(load, load_val, dec);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs0 !== exp_vec(cnt[0], md[0], mb[0])) begin
      errors++;
      $display("FAIL reset_async w0 got=%h exp=%h", obs0, exp_vec(cnt[0], md[0], mb[0]));
    end
    tick();
    tick();
    #2;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (obs0 !== exp_vec(cnt[0], md[0], mb[0])) begin
        errors++;
        $display("FAIL reset_release w0 got=%h exp=%h", obs0, exp_vec(cnt[0], md[0], mb[0]));
      end
      checks++;
      if (obs1 !== exp_vec(cnt[1], md[1], mb[1])) begin
        errors++;
        $display("FAIL reset_release w1 got=%h exp=%h", obs1, exp_vec(cnt[1], md[1], mb[1]));
      end
    end
  endtask

  task automatic test_load_dec();
    load = 1'b1; load_val = 12'h100;
    tick();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dec = (k < 2);
      tick();
      checks++;
      if (obs0 !== exp_vec(cnt[0], md[0], mb[0])) begin
        errors++;
        $display("FAIL load_dec w0 step%0d got=%h exp=%h", k, obs0,
                 exp_vec(cnt[0], md[0], mb[0]));
      end
      checks++;
      if (obs1 !== exp_vec(cnt[1], md[1], mb[1])) begin
        errors++;
        $display("FAIL load_dec w1 step%0d got=%h exp=%h", k, obs1,
                 exp_vec(cnt[1], md[1], mb[1]));
      end
    end
    dec = 1'b0;
  endtask

  task automatic test_done_hold();
    load = 1'b1; load_val = 12'h002;
    tick();
    load = 1'b0;
    dec  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) dec = 1'b0;
      tick();
      checks++;
      if (obs0 !== exp_vec(cnt[0], md[0], mb[0])) begin
        errors++;
        $display("FAIL done_hold w0 cyc%0d got=%h exp=%h", k, obs0,
                 exp_vec(cnt[0], md[0], mb[0]));
      end
      checks++;
      if (obs1 !== exp_vec(cnt[1], md[1], mb[1])) begin
        errors++;
        $display("FAIL done_hold w1 cyc%0d got=%h exp=%h", k, obs1,
                 exp_vec(cnt[1], md[1], mb[1]));
      end
    end
  endtask

  task automatic test_wrap();
    load = 1'b1; load_val = 12'h000;
    tick();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dec = (k == 0);
      tick();
      checks++;
      if (obs0 !== exp_vec(cnt[0], md[0], mb[0])) begin
        errors++;
        $display("FAIL wrap w0 cyc%0d got=%h exp=%h", k, obs0, exp_vec(cnt[0], md[0], mb[0]));
      end
      checks++;
      if (obs1 !== exp_vec(cnt[1], md[1], mb[1])) begin
        errors++;
        $display("FAIL wrap w1 cyc%0d got=%h exp=%h", k, obs1, exp_vec(cnt[1], md[1], mb[1]));
      end
    end
    dec = 1'b0;
  endtask

  task automatic test_load_priority();
    logic [11:0] vals [3] = '{12'h050, 12'hFAB, 12'h1A5};
    for (int k = 0; k < 3; k++) begin
      load = 1'b1; dec = 1'b1; load_val = vals[k];
      tick();
      checks++;
      if (obs0 !== exp_vec(cnt[0], md[0], mb[0])) begin
        errors++;
        $display("FAIL load_prio w0 val=%h got=%h exp=%h", vals[k], obs0,
                 exp_vec(cnt[0], md[0], mb[0]));
      end
      checks++;
      if (obs1 !== exp_vec(cnt[1], md[1], mb[1])) begin
        errors++;
        $display("FAIL load_prio w1 val=%h got=%h exp=%h", vals[k], obs1,
                 exp_vec(cnt[1], md[1], mb[1]));
      end
    end
    load = 1'b0; dec = 1'b0;
  endtask

  task automatic test_sweep();
    load = 1'b1; load_val = 12'h010;
    tick();
    load = 1'b0;
    for (int k = 0; k < 22; k++) begin
      dec = (k % 2 == 0);
      tick();
      checks++;
      if (obs0 !== exp_vec(cnt[0], md[0], mb[0])) begin
        errors++;
        $display("FAIL sweep w0 cyc%0d got=%h exp=%h", k, obs0, exp_vec(cnt[0], md[0], mb[0]));
      end
    end
    dec = 1'b0;
  endtask

  task automatic test_reset_midcount();
    load = 1'b1; load_val = 12'h057;
    tick();
    load = 1'b0; dec = 1'b1;
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs0 !== exp_vec(cnt[0], md[0], mb[0])) begin
      errors++;
      $display("FAIL reset_mid w0 got=%h exp=%h", obs0, exp_vec(cnt[0], md[0], mb[0]));
    end
    checks++;
    if (obs1 !== exp_vec(cnt[1], md[1], mb[1])) begin
      errors++;
      $display("FAIL reset_mid w1 got=%h exp=%h", obs1, exp_vec(cnt[1], md[1], mb[1]));
    end
    dec = 1'b0;
    tick();
    #2;
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      load = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) load_val = 12'($urandom_range(0, 3));
      else load_val = 12'($urandom);
      dec = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (obs0 !== exp_vec(cnt[0], md[0], mb[0])) begin
        errors++;
        $display("FAIL random w0 cyc%0d got=%h exp=%h", k, obs0, exp_vec(cnt[0], md[0], mb[0]));
      end
      checks++;
      if (obs1 !== exp_vec(cnt[1], md[1], mb[1])) begin
        errors++;
        $display("FAIL random w1 cyc%0d got=%h exp=%h", k, obs1, exp_vec(cnt[1], md[1], mb[1]));
      end
    end
    load = 1'b0; dec = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_dec();
    test_done_hold();
    test_wrap();
    test_load_priority();
    test_sweep();
    test_reset_midcount();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
